backing_ram: RTL
================

BACKING_RAM -- requirements
Module: backing_ram

Parameters
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 16, giving the byte-address width shared with the cache's RAM port.
REQ-002 The block SHALL have parameter LATENCY, default 4, giving the cycles from request sample to response; legal range 1..15, and elaboration SHALL fail with $fatal if LATENCY < 1.
REQ-003 The block SHALL have localparam DEPTH = 2**(ADDRESS_WIDTH-2), giving the number of 32-bit words stored.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port ram_address, input, ADDRESS_WIDTH bits: byte address; bits [1:0] ignored, bits [ADDRESS_WIDTH-1:2] form the word index.
REQ-007 The block SHALL have port ram_rd, input, 1 bit: read request strobe.
REQ-008 The block SHALL have port ram_wr, input, 1 bit: write request strobe.
REQ-009 The block SHALL have port ram_data_wr, input, 32 bits: full-word write data.
REQ-010 The block SHALL have port ram_data_rd, output, 32 bits: read data, meaningful only while ram_data_valid=1.
REQ-011 The block SHALL have port ram_data_valid, output, 1 bit: one-cycle completion pulse for both reads and writes.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a request is outstanding (states WAIT and RESPOND).
REQ-013 The block SHALL have port protocol_error, output, 1 bit: sticky flag, cleared only by rst.

Function
REQ-014 The block SHALL implement the state machine IDLE -> WAIT -> RESPOND -> IDLE; no other states reachable.
REQ-015 In IDLE, when ram_rd|ram_wr=1 at a rising edge, the block SHALL latch ram_address[ADDRESS_WIDTH-1:2], ram_data_wr and the op (write if ram_wr, else read), load latency counter with LATENCY-1, and go to WAIT.
REQ-016 In WAIT, the counter SHALL decrement each cycle; when it is 0 at an edge, the block SHALL go to RESPOND, registering ram_data_valid=1 for that cycle.
REQ-017 Timing: with request sampled at edge N, ram_data_valid SHALL be high for exactly the cycle after edge N+LATENCY; for LATENCY=1 that is the cycle after edge N+1, so WAIT is occupied for one cycle.
REQ-018 A read SHALL drive ram_data_rd = mem[latched index] during the RESPOND cycle, registered from the array on the edge entering RESPOND.
REQ-019 A write SHALL update mem[latched index] with the latched data on the edge entering RESPOND; ram_data_rd SHALL hold its previous value.
REQ-020 RESPOND SHALL last exactly one cycle and then return to IDLE, ignoring ram_rd/ram_wr presented during RESPOND.
REQ-021 The earliest next request SHALL be sampled on the edge that ends the IDLE cycle following RESPOND; back-to-back requests SHALL therefore be spaced at least LATENCY+2 cycles apart.
REQ-022 If ram_rd=1 and ram_wr=1 are sampled together in IDLE, the block SHALL perform the write and set protocol_error.
REQ-023 If ram_rd or ram_wr is asserted while the block is in WAIT, the request SHALL be dropped with no state change and protocol_error SHALL be set.
REQ-024 The latched address and data SHALL remain stable while in WAIT, regardless of input changes.
REQ-025 A read-after-write to the same word SHALL return the newly written data.
REQ-026 Word index wrap SHALL NOT occur: every index 0..DEPTH-1 maps to a distinct word.

Reset
REQ-027 Asserting rst SHALL immediately force state IDLE, counter 0, ram_data_valid=0, busy=0, protocol_error=0, ram_data_rd=0 and latched registers 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 rst asserted mid-request (in WAIT or RESPOND) SHALL abort the request; an aborted write SHALL leave memory unmodified if the abort occurs before the edge entering RESPOND.
REQ-030 After rst deasserts, the first edge with rst low SHALL be able to sample a request.

Verification
REQ-031 The bench SHALL cover: LATENCY=4, write 0xDEADBEEF to address 0x0010, then read 0x0012 -> ram_data_valid each pulses exactly 4 cycles after the sample edge, and the read returns 0xDEADBEEF.
REQ-032 The bench SHALL cover: LATENCY=1, write 0x11111111 to 0x0000 and 0x22222222 to 0xFFFC, then read both -> 0x11111111 and 0x22222222 with no aliasing; valid pulses 1 cycle after each sample.
REQ-033 The bench SHALL cover: ram_rd pulsed again 2 cycles into a LATENCY=4 read -> only one valid pulse, protocol_error=1 and stays high until rst.
REQ-034 The bench SHALL cover: ram_rd=ram_wr=1 with data 0xA5A5A5A5 at 0x0040 -> write performed, protocol_error=1, a later read of 0x0040 returns 0xA5A5A5A5.
REQ-035 The bench SHALL cover: rst asserted one cycle after a write request to 0x0080 (LATENCY=4), then 0x0080 read after reset -> outputs zero during rst, and the read returns the pre-request contents.
REQ-036 The bench SHALL cover: the cache's 4-word miss-fill sequence (ram_rd strobed the cycle after each valid) -> 4 valid pulses with increasing word data, busy low only between requests, protocol_error=0.

Source files
------------

// File: rtl/backing_ram_if.sv
// Cache-to-backing-RAM request/response bundle. The master drives requests and
// the slave returns completion, read data and status.
interface backing_ram_if #(
    parameter int ADDRESS_WIDTH = 16
);
    logic [ADDRESS_WIDTH-1:0] ram_address;
    logic                     ram_rd;
    logic                     ram_wr;
    logic [31:0]              ram_data_wr;
    logic [31:0]              ram_data_rd;
    logic                     ram_data_valid;
    logic                     busy;
    logic                     protocol_error;

    modport master (
        output ram_address, ram_rd, ram_wr, ram_data_wr,
        input  ram_data_rd, ram_data_valid, busy, protocol_error
    );

    modport slave (
        input  ram_address, ram_rd, ram_wr, ram_data_wr,
        output ram_data_rd, ram_data_valid, busy, protocol_error
    );
endinterface

// File: rtl/backing_ram.sv
// Word-addressed backing store with a fixed response latency. It accepts one request
// at a time and gives a single-cycle valid pulse for both reads and writes.
module backing_ram #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int LATENCY       = 4
) (
    input  logic        clk,
    input  logic        rst,
    backing_ram_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);
    localparam int IW    = ADDRESS_WIDTH - 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "backing_ram: LATENCY must be in 1..15");
    end

    logic [31:0]   mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          is_wr_q, is_wr_d;
    logic          valid_q, valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          perr_q, perr_d;
    logic          mem_we;
    logic          req;

    // Byte-offset bits carry no meaning for a full-word store.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.ram_address[1:0];

    assign req = bus.ram_rd | bus.ram_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = bus.ram_address[ADDRESS_WIDTH-1:2];
                    wdata_d = bus.ram_data_wr;
                    is_wr_d = bus.ram_wr;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                    if (bus.ram_rd && bus.ram_wr) perr_d = 1'b1;
                end
            end
            S_WAIT: begin
                // Requests arriving mid-flight are dropped but remembered as an error.
                if (req) perr_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    valid_d = 1'b1;
                    if (is_wr_q) mem_we  = 1'b1;
                    else         rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= wdata_q;
    end

    assign bus.ram_data_rd    = rdata_q;
    assign bus.ram_data_valid = valid_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.protocol_error = perr_q;
endmodule
